// File: rtl/stim_pulse_gen.sv
// Multi-channel programmable pulse-train generator: per-channel period/width/count, start/stop, done pulse.
// Optional macro STIM_PULSE_GEN_CLK_GATE_EN ANDs each level with clk for clock-rate bursts.
module stim_pulse_gen #(
  parameter  int NCH = 4,
  parameter  int CW  = 16,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_width,
  input  logic [CW-1:0]  cfg_count,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] stim_out,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic           cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  state_t         st_r   [NCH];
  logic [CW-1:0]  per_r  [NCH];
  logic [CW-1:0]  wid_r  [NCH];
  logic [CW-1:0]  num_r  [NCH];
  logic [CW-1:0]  cnt_r  [NCH];
  logic [CW-1:0]  pcnt_r [NCH];
  logic [NCH-1:0] level_r;

  logic ch_ok;
  logic cfg_acc;
  logic cfg_bad;

  // Channel numbers beyond NCH (non power-of-two NCH) are accepted and flagged illegal.
  assign ch_ok     = (32'(cfg_ch) < NCH);
  assign cfg_ready = ch_ok ? !busy[cfg_ch] : 1'b1;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign cfg_bad   = !ch_ok || (cfg_period < TWO) || (cfg_width == ZERO) ||
                     (cfg_width >= cfg_period);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
      level_r <= '0;
      busy    <= '0;
      done    <= '0;
      for (int i = 0; i < NCH; i++) begin
        st_r[i]   <= IDLE;
        per_r[i]  <= TWO;
        wid_r[i]  <= ONE;
        num_r[i]  <= ONE;
        cnt_r[i]  <= ZERO;
        pcnt_r[i] <= ZERO;
      end
    end else begin
      cfg_err <= cfg_acc && cfg_bad;
      for (int i = 0; i < NCH; i++) begin
        done[i] <= 1'b0;
        if (cfg_acc && !cfg_bad && (cfg_ch == CHW'(i))) begin
          per_r[i] <= cfg_period;
          wid_r[i] <= cfg_width;
          num_r[i] <= cfg_count;
        end
        if (stop[i]) begin
          st_r[i]    <= IDLE;
          level_r[i] <= 1'b0;
          busy[i]    <= 1'b0;
          cnt_r[i]   <= ZERO;
          pcnt_r[i]  <= ZERO;
        end else begin
          case (st_r[i])
            IDLE: begin
              if (start[i]) begin
                st_r[i]    <= HIGH;
                level_r[i] <= 1'b1;
                busy[i]    <= 1'b1;
                cnt_r[i]   <= ZERO;
                pcnt_r[i]  <= ZERO;
              end
            end
            HIGH: begin
              if (cnt_r[i] == wid_r[i] - ONE) begin
                pcnt_r[i] <= pcnt_r[i] + ONE;
                // Last pulse with a one-cycle low phase: that low cycle is the done cycle.
                if ((num_r[i] != ZERO) && (pcnt_r[i] + ONE == num_r[i]) &&
                    (wid_r[i] == per_r[i] - ONE)) begin
                  st_r[i]    <= IDLE;
                  level_r[i] <= 1'b0;
                  busy[i]    <= 1'b0;
                  done[i]    <= 1'b1;
                  cnt_r[i]   <= ZERO;
                end else begin
                  st_r[i]    <= LOW;
                  level_r[i] <= 1'b0;
                  cnt_r[i]   <= cnt_r[i] + ONE;
                end
              end else begin
                cnt_r[i] <= cnt_r[i] + ONE;
              end
            end
            LOW: begin
              if ((num_r[i] != ZERO) && (pcnt_r[i] == num_r[i]) &&
                  (cnt_r[i] == per_r[i] - TWO)) begin
                st_r[i]  <= IDLE;
                busy[i]  <= 1'b0;
                done[i]  <= 1'b1;
                cnt_r[i] <= ZERO;
              end else if (cnt_r[i] == per_r[i] - ONE) begin
                st_r[i]    <= HIGH;
                level_r[i] <= 1'b1;
                cnt_r[i]   <= ZERO;
              end else begin
                cnt_r[i] <= cnt_r[i] + ONE;
              end
            end
            default: begin
              st_r[i]    <= IDLE;
              level_r[i] <= 1'b0;
              busy[i]    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef STIM_PULSE_GEN_CLK_GATE_EN
  assign stim_out = level_r & {NCH{clk}};
`else
  assign stim_out = level_r;
`endif

endmodule

// File: tb/tb_stim_pulse_gen.sv
// Bench for stim_pulse_gen: directed spec scenarios then random traffic against a pulse-train reference model.
module tb_stim_pulse_gen;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_width;
  logic [CW-1:0]  cfg_count;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] stim_out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
  logic           cfg_err;

  always #5 clk = ~clk;

  stim_pulse_gen #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_width(cfg_width),
    .cfg_count(cfg_count), .start(start), .stop(stop), .stim_out(stim_out),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [NCH-1:0] stim;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Reference model: programmed registers, plus a snapshot of the train launched at edge m_s.
  int             m_p[NCH], m_w[NCH], m_n[NCH];
  int             r_p[NCH], r_w[NCH], r_n[NCH];
  bit             m_run[NCH];
  int             m_s[NCH];
  logic [NCH-1:0] m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, edge_no, act, req);
    end
  endtask

  task automatic step(input logic r, input logic cv, input int ch, input int p, input int w,
                      input int n, input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    exp_t e;
    int   d;
    @(negedge clk);
    rst        = r;
    cfg_valid  = cv;
    cfg_ch     = 2'(ch);
    cfg_period = CW'(p);
    cfg_width  = CW'(w);
    cfg_count  = CW'(n);
    start      = st;
    stop       = sp;
    #1;
    if (!r) check("cfg_ready", 32'(cfg_ready), 32'(!m_busy[ch]));
    e = '0;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_p[i] = 2; m_w[i] = 1; m_n[i] = 1; m_run[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sp[i]) begin
          m_run[i] = 0;
        end else if (m_run[i]) begin
          d = edge_no - m_s[i] + 1;
          if (r_n[i] != 0 && d == r_n[i] * r_p[i]) begin
            e.done[i] = 1'b1;
            m_run[i]  = 0;
          end else begin
            e.busy[i] = 1'b1;
            e.stim[i] = (((d - 1) % r_p[i]) < r_w[i]);
          end
        end else if (st[i]) begin
          m_run[i] = 1; m_s[i] = edge_no;
          r_p[i] = m_p[i]; r_w[i] = m_w[i]; r_n[i] = m_n[i];
          e.busy[i] = 1'b1;
          e.stim[i] = 1'b1;
        end
      end
      if (cv && !m_busy[ch]) begin
        if (p < 2 || w == 0 || w >= p) e.err = 1'b1;
        else begin
          m_p[ch] = p; m_w[ch] = w; m_n[ch] = n;
        end
      end
    end
    m_busy = e.busy;
    exp_q.push_back(e);
    edge_no++;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(1'b0, 1'b0, 0, 0, 0, 0, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stim_out", 32'(stim_out), 32'(e.stim));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
        check("cfg_err", 32'(cfg_err), 32'(e.err));
      end
    end
  end

  initial begin : driver
    logic [NCH-1:0] st, sp;
    int ch;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_width = '0;
    cfg_count = '0; start = '0; stop = '0; m_busy = '0;
    for (int i = 0; i < NCH; i++) begin
      m_p[i] = 2; m_w[i] = 1; m_n[i] = 1; m_run[i] = 0; m_s[i] = 0;
      r_p[i] = 2; r_w[i] = 1; r_n[i] = 1;
    end
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 0, 0, 0, 0, '0, '0);
    idle(2);

    // Three-pulse train on ch0; writes to the busy channel must stall.
    step(1'b0, 1'b1, 0, 5, 2, 3, '0, '0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b0001, '0);
    for (int j = 0; j < 17; j++) step(1'b0, 1'b1, 0, 5, 2, 3, '0, '0);

    // Continuous train on ch1, stopped after ten cycles.
    step(1'b0, 1'b1, 1, 4, 1, 0, '0, '0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b0010, '0);
    idle(9);
    step(1'b0, 1'b0, 0, 0, 0, 0, '0, 4'b0010);
    idle(3);

    // Illegal writes leave ch2 at reset defaults.
    step(1'b0, 1'b1, 2, 3, 3, 2, '0, '0);
    step(1'b0, 1'b1, 2, 1, 0, 2, '0, '0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b0100, '0);
    idle(4);

    // Start+stop together from IDLE, then start while busy.
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b0001, 4'b0001);
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b0001, '0);
    idle(3);
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b0001, '0);
    idle(14);

    // Reset during a HIGH phase of ch3.
    step(1'b0, 1'b1, 3, 6, 3, 0, '0, '0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b1111, '0);
    step(1'b0, 1'b0, 0, 0, 0, 0, '0, '0);
    step(1'b1, 1'b1, 3, 5, 2, 2, 4'b1000, '0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 4'b1000, '0);
    idle(3);

    for (int k = 0; k < 3000; k++) begin
      st = '0; sp = '0;
      for (int i = 0; i < NCH; i++) begin
        st[i] = ($urandom_range(0, 5) == 0);
        sp[i] = ($urandom_range(0, 49) == 0);
      end
      ch = int'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 3) == 0) begin
        st[ch] = 1'b0;
        step(($urandom_range(0, 499) == 0), 1'b1, ch, int'($urandom_range(0, 8)),
             int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), st, sp);
      end else begin
        step(($urandom_range(0, 499) == 0), 1'b0, ch, 0, 0, 0, st, sp);
      end
    end

    idle(2);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
